// File: rtl/reveal_win_check.sv
// reveal_win_check: scans every cell of the reveal and mine memories and
// reports the scan result to game_state.
//
// The scan issues all GRID_W*GRID_H read addresses in ascending order. It then
// waits RD_LATENCY cycles so the last read data can return. After that it
// reports how many cells are revealed, whether the player has won, and whether
// a mine has been revealed.
//
// Ports:
//   i_clk            system clock, rising edge
//   i_rst_n          asynchronous active-low reset
//   i_check_en       level request from game_state to start a scan
//   o_mem_rd_addr    {y[3:0], x[3:0]}, shared read address for both memories
//   i_reveal_mem_q   reveal memory read data, 1 = revealed
//   i_mine_mem_q     mine memory read data, 1 = mine
//   o_check_done     result valid, high while results are being reported
//   o_revealed_count number of revealed cells, 0..256
//   o_win            every non-mine cell revealed and no mine revealed
//   o_lose           at least one revealed cell holds a mine
module reveal_win_check #(
  parameter int unsigned GRID_W     = 16,
  parameter int unsigned GRID_H     = 16,
  parameter int unsigned RD_LATENCY = 1   // 1 or 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_check_en,
  output logic [7:0] o_mem_rd_addr,
  input  logic       i_reveal_mem_q,
  input  logic       i_mine_mem_q,
  output logic       o_check_done,
  output logic [8:0] o_revealed_count,
  output logic       o_win,
  output logic       o_lose
);

  typedef enum logic [1:0] {StIdle, StScan, StDrain, StDone} state_e;

  localparam logic [3:0] XMax      = 4'(GRID_W - 1);
  localparam logic [3:0] YMax      = 4'(GRID_H - 1);
  localparam logic [1:0] DrainLast = 2'(RD_LATENCY - 1);

  state_e                r_state, w_state_d;
  logic [3:0]            r_x, w_x_d;
  logic [3:0]            r_y, w_y_d;
  logic [RD_LATENCY-1:0] r_valid, w_valid_d;
  logic [1:0]            r_drain_cnt, w_drain_cnt_d;
  logic [8:0]            r_count, w_count_d;
  logic [8:0]            r_safe_cnt, w_safe_cnt_d;   // unrevealed non-mine cells
  logic                  r_win, w_win_d;
  logic                  r_lose, w_lose_d;
  logic                  w_last_addr;
  logic                  w_sample;

  assign w_last_addr = (r_x == XMax) && (r_y == YMax);
  // The oldest stage of the tag pipe marks the cycle in which read data is valid.
  assign w_sample    = r_valid[RD_LATENCY-1];

  always_comb begin
    w_state_d     = r_state;
    w_x_d         = r_x;
    w_y_d         = r_y;
    w_drain_cnt_d = r_drain_cnt;
    w_count_d     = r_count;
    w_safe_cnt_d  = r_safe_cnt;
    w_win_d       = r_win;
    w_lose_d      = r_lose;

    // Tag every address issued during the scan and carry the tag along with the read.
    w_valid_d[0] = (r_state == StScan);
    for (int i = 1; i < int'(RD_LATENCY); i++) begin
      w_valid_d[i] = r_valid[i-1];
    end

    // Accumulate before the state decode. This way the win decision taken on
    // DONE entry includes the final sample.
    if (w_sample) begin
      if (i_reveal_mem_q) begin
        w_count_d = r_count + 9'd1;
      end
      if (i_reveal_mem_q && i_mine_mem_q) begin
        w_lose_d = 1'b1;
      end
      if (!i_reveal_mem_q && !i_mine_mem_q) begin
        w_safe_cnt_d = r_safe_cnt + 9'd1;
      end
    end

    unique case (r_state)
      StIdle: begin
        if (i_check_en) begin
          w_state_d    = StScan;
          w_x_d        = 4'd0;
          w_y_d        = 4'd0;
          w_count_d    = 9'd0;
          w_safe_cnt_d = 9'd0;
          w_lose_d     = 1'b0;
          w_win_d      = 1'b0;
        end
      end
      StScan: begin
        if (w_last_addr) begin
          w_state_d     = StDrain;
          w_x_d         = 4'd0;
          w_y_d         = 4'd0;
          w_drain_cnt_d = 2'd0;
        end else if (r_x == XMax) begin
          w_x_d = 4'd0;
          w_y_d = r_y + 4'd1;
        end else begin
          w_x_d = r_x + 4'd1;
        end
      end
      StDrain: begin
        if (r_drain_cnt == DrainLast) begin
          w_state_d = StDone;
          w_win_d   = (w_safe_cnt_d == 9'd0) && !w_lose_d;
        end else begin
          w_drain_cnt_d = r_drain_cnt + 2'd1;
        end
      end
      StDone: begin
        if (!i_check_en) begin
          w_state_d = StIdle;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_x         <= 4'd0;
      r_y         <= 4'd0;
      r_valid     <= '0;
      r_drain_cnt <= 2'd0;
      r_count     <= 9'd0;
      r_safe_cnt  <= 9'd0;
      r_win       <= 1'b0;
      r_lose      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_x         <= w_x_d;
      r_y         <= w_y_d;
      r_valid     <= w_valid_d;
      r_drain_cnt <= w_drain_cnt_d;
      r_count     <= w_count_d;
      r_safe_cnt  <= w_safe_cnt_d;
      r_win       <= w_win_d;
      r_lose      <= w_lose_d;
    end
  end

  assign o_mem_rd_addr    = (r_state == StScan) ? {r_y, r_x} : 8'd0;
  assign o_check_done     = (r_state == StDone);
  assign o_revealed_count = r_count;
  assign o_win            = r_win;
  assign o_lose           = r_lose;

endmodule

// File: tb/tb_reveal_win_check.sv
// Testbench for reveal_win_check. Two instances run side by side, one with
// RD_LATENCY=1 and one with RD_LATENCY=2, and both read the same memory maps.
// Each instance gets its own memory model with the matching read latency.
// Expected results are computed from the maps and pushed into a queue when a
// scan is requested. A monitor pops an entry whenever check_done rises.
module tb_reveal_win_check;

  typedef struct {
    int start;   // cycle index of the edge that samples check_en
    int cnt;
    bit win;
    bit lose;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       check_en;
  logic [7:0] addr0, addr1;
  logic       rq0, mq0, rq1, mq1, rq1a, mq1a;
  logic       done0, done1;
  logic [8:0] cnt0, cnt1;
  logic       win0, win1, lose0, lose1;

  bit   reveal_map [256];
  bit   mine_map   [256];
  exp_t q0 [$];
  exp_t q1 [$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   addr_bad [2];
  bit   done_prev [2];

  reveal_win_check #(.GRID_W(16), .GRID_H(16), .RD_LATENCY(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_check_en(check_en), .o_mem_rd_addr(addr0),
    .i_reveal_mem_q(rq0), .i_mine_mem_q(mq0), .o_check_done(done0),
    .o_revealed_count(cnt0), .o_win(win0), .o_lose(lose0)
  );

  reveal_win_check #(.GRID_W(16), .GRID_H(16), .RD_LATENCY(2)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_check_en(check_en), .o_mem_rd_addr(addr1),
    .i_reveal_mem_q(rq1), .i_mine_mem_q(mq1), .o_check_done(done1),
    .o_revealed_count(cnt1), .o_win(win1), .o_lose(lose1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read memories, 1 and 2 cycles of latency.
  always @(posedge clk) begin
    rq0  <= reveal_map[addr0];
    mq0  <= mine_map[addr0];
    rq1a <= reveal_map[addr1];
    mq1a <= mine_map[addr1];
    rq1  <= rq1a;
    mq1  <= mq1a;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference result computed directly from the game rules.
  function automatic exp_t model();
    exp_t e;
    int   unrevealed_safe;
    e.cnt = 0;
    e.lose = 0;
    unrevealed_safe = 0;
    for (int a = 0; a < 256; a++) begin
      if (reveal_map[a]) e.cnt++;
      if (reveal_map[a] && mine_map[a]) e.lose = 1;
      if (!reveal_map[a] && !mine_map[a]) unrevealed_safe++;
    end
    e.win = (unrevealed_safe == 0) && !e.lose;
    e.start = 0;
    return e;
  endfunction

  // Monitor: checks the address stream every cycle and the results on each check_done rise.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      exp_t     e;
      bit       have;
      bit       d;
      int       lat;
      int       exp_addr;
      int       act_addr;
      int       act_cnt;
      bit       act_win, act_lose;
      lat      = i + 1;
      have     = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
      if (have) e = (i == 0) ? q0[0] : q1[0];
      d        = (i == 0) ? done0 : done1;
      act_addr = (i == 0) ? int'(addr0) : int'(addr1);
      act_cnt  = (i == 0) ? int'(cnt0) : int'(cnt1);
      act_win  = (i == 0) ? win0 : win1;
      act_lose = (i == 0) ? lose0 : lose1;
      exp_addr = 0;
      if (have && cyc >= e.start && cyc <= e.start + 255) exp_addr = cyc - e.start;
      if (act_addr != exp_addr) addr_bad[i]++;
      if (d && !done_prev[i]) begin
        if (!have) begin
          check($sformatf("unexpected_done[L%0d]", lat), 1, 0);
        end else begin
          check($sformatf("done_latency[L%0d]", lat), cyc - e.start, 256 + lat);
          check($sformatf("revealed_count[L%0d]", lat), act_cnt, e.cnt);
          check($sformatf("win[L%0d]", lat), int'(act_win), int'(e.win));
          check($sformatf("lose[L%0d]", lat), int'(act_lose), int'(e.lose));
          check($sformatf("addr_sequence_errors[L%0d]", lat), addr_bad[i], 0);
          addr_bad[i] = 0;
          if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
      end else if (have && cyc > e.start + 256 + lat + 4) begin
        check($sformatf("done_timeout[L%0d]", lat), 0, 1);
        if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
      done_prev[i] = d;
    end
  end

  task automatic check_results(input string tag, input exp_t e, input bit done_exp);
    check({tag, "_cnt[L1]"}, int'(cnt0), e.cnt);
    check({tag, "_cnt[L2]"}, int'(cnt1), e.cnt);
    check({tag, "_win[L1]"}, int'(win0), int'(e.win));
    check({tag, "_win[L2]"}, int'(win1), int'(e.win));
    check({tag, "_lose[L1]"}, int'(lose0), int'(e.lose));
    check({tag, "_lose[L2]"}, int'(lose1), int'(e.lose));
    check({tag, "_done[L1]"}, int'(done0), int'(done_exp));
    check({tag, "_done[L2]"}, int'(done1), int'(done_exp));
  endtask

  // Call at a negedge with both DUTs idle.
  task automatic run_scan(input bit pulse);
    exp_t e;
    exp_t z;
    int   n;
    e = model();
    e.start = cyc + 1;
    q0.push_back(e);
    q1.push_back(e);
    check_en = 1'b1;
    @(negedge clk);
    z.cnt = 0; z.win = 0; z.lose = 0; z.start = 0;
    check_results("clear_at_start", z, 1'b0);
    if (pulse) check_en = 1'b0;
    n = 0;
    while (!done1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!done1) check("wait_done", 0, 1);
    if (pulse) begin
      check("pulse_done_one_cycle[L1]", int'(done0), 0);
      repeat (3) @(negedge clk);
      check_results("held_in_idle", e, 1'b0);
    end else begin
      repeat (3) @(negedge clk);
      check_results("held_in_done", e, 1'b1);
      check_en = 1'b0;
      @(negedge clk);
      check_results("held_after_drop", e, 1'b0);
    end
  endtask

  task automatic fill_map(input bit rev, input bit mine);
    for (int a = 0; a < 256; a++) begin
      reveal_map[a] = rev;
      mine_map[a]   = mine;
    end
  endtask

  // kind 0: random reveals; kind 1: all safe cells revealed; kind 2: kind 1 plus a revealed mine
  task automatic random_map(input int kind);
    int m;
    for (int a = 0; a < 256; a++) begin
      mine_map[a]   = ($urandom_range(7) == 0);
      reveal_map[a] = (kind == 0) ? bit'($urandom_range(1)) : !mine_map[a];
    end
    if (kind == 2) begin
      m = $urandom_range(255);
      mine_map[m]   = 1'b1;
      reveal_map[m] = 1'b1;
    end
  endtask

  task automatic mark_mines_00_ff();
    fill_map(1'b1, 1'b0);
    mine_map[8'h00]   = 1'b1;
    reveal_map[8'h00] = 1'b0;
    mine_map[8'hFF]   = 1'b1;
    reveal_map[8'hFF] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t z;
    int   n;
    z.cnt = 0; z.win = 0; z.lose = 0; z.start = 0;
    addr_bad[0] = 0; addr_bad[1] = 0;
    done_prev[0] = 0; done_prev[1] = 0;
    rst_n    = 1'b0;
    check_en = 1'b0;
    fill_map(1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check_results("reset", z, 1'b0);
    check("reset_addr[L1]", int'(addr0), 0);
    check("reset_addr[L2]", int'(addr1), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // All-zero memories, check_en held.
    run_scan(1'b0);
    // Mines at 0x00 and 0xFF, everything else revealed.
    mark_mines_00_ff();
    run_scan(1'b0);
    // Same map with 0x45 revealed and mined.
    mine_map[8'h45] = 1'b1;
    run_scan(1'b1);
    // Same map with safe cell 0x80 left unrevealed.
    mark_mines_00_ff();
    reveal_map[8'h80] = 1'b0;
    run_scan(1'b0);
    // Every cell revealed, no mines: count reaches 256.
    fill_map(1'b1, 1'b0);
    run_scan(1'b0);
    // Single-cycle requests with changing maps.
    random_map(0);
    run_scan(1'b1);
    random_map(1);
    run_scan(1'b1);

    // Reset mid-scan at address 0x7A.
    random_map(0);
    begin
      exp_t e;
      e = model();
      e.start = cyc + 1;
      q0.push_back(e);
      q1.push_back(e);
      check_en = 1'b1;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (addr0 != 8'h7A && n < 400);
      check("reached_addr_7a", int'(addr0), 'h7A);
      #2 rst_n = 1'b0;
      #1;
      check_results("async_reset", z, 1'b0);
      check("async_reset_addr[L1]", int'(addr0), 0);
      check("async_reset_addr[L2]", int'(addr1), 0);
      q0.delete();
      q1.delete();
      addr_bad[0] = 0;
      addr_bad[1] = 0;
      check_en = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
    end
    random_map(2);
    run_scan(1'b0);

    for (int k = 0; k < 6; k++) begin
      random_map(k % 3);
      run_scan(bit'($urandom_range(1)));
    end

    repeat (3) @(negedge clk);
    check("queue_empty[L1]", q0.size(), 0);
    check("queue_empty[L2]", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
